// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencer.
package div_ctrl_pkg;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_EXC     = 3'd5
  } div_state_t;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl.sv
// Sequencer for the iterative divider: latches operands, screens divide-by-zero,
// pulses init, counts the iteration cycles and captures the result into HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic              hi_wr,
  input  logic              lo_wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic              divCtrl,
  output logic [DATA_W-1:0] div_srcA,
  output logic [DATA_W-1:0] div_srcB,
  output logic              busy,
  output logic              done,
  output logic              div_zero_exc,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] srca_q, srca_d;
  logic [DATA_W-1:0] srcb_q, srcb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              divctrl_q, divctrl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              exc_q, exc_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;
        if (start) begin
          if (srcB == '0) begin
            state_d = ST_EXC;
          end else begin
            srca_d  = srcA;
            srcb_d  = srcB;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        hi_d    = div_hi;
        lo_d    = div_lo;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are a function of the state being entered, so they can be flopped.
    divctrl_d = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_CAPTURE);
    done_d    = (state_d == ST_DONE);
    exc_d     = (state_d == ST_EXC);
  end

  // State, counter, operand, HI/LO and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divctrl_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      srca_q    <= srca_d;
      srcb_q    <= srcb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divctrl_q <= divctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
    end
  end

  assign divCtrl      = divctrl_q;
  assign div_srcA     = srca_q;
  assign div_srcB     = srcb_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = exc_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl paired with a behavioural 32-step restoring divider.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] srcA, srcB;
  logic        hi_wr, lo_wr;
  logic [31:0] wr_data;
  logic [31:0] div_hi, div_lo;
  logic        divCtrl;
  logic [31:0] div_srcA, div_srcB;
  logic        busy, done, div_zero_exc;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int divctrl_cnt = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .srcA(srcA), .srcB(srcB),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .div_hi(div_hi), .div_lo(div_lo), .divCtrl(divCtrl),
    .div_srcA(div_srcA), .div_srcB(div_srcB), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo)
  );

  // Divider stand-in: init on divCtrl, then one restoring step per edge for 32 edges.
  logic [31:0] d_rem, d_quo, d_den;
  logic [5:0]  d_cnt;
  logic [32:0] d_t;
  logic [32:0] d_sub;
  always_comb begin
    d_t   = {d_rem, d_quo[31]};
    d_sub = d_t - {1'b0, d_den};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_rem <= '0; d_quo <= '0; d_den <= '0; d_cnt <= '0;
    end else if (divCtrl) begin
      d_rem <= '0; d_quo <= div_srcA; d_den <= div_srcB; d_cnt <= 6'd32;
    end else if (d_cnt != 6'd0) begin
      d_cnt <= d_cnt - 6'd1;
      if (d_t >= {1'b0, d_den}) begin
        d_rem <= d_sub[31:0];
        d_quo <= {d_quo[30:0], 1'b1};
      end else begin
        d_rem <= d_t[31:0];
        d_quo <= {d_quo[30:0], 1'b0};
      end
    end
  end
  assign div_hi = d_rem;
  assign div_lo = d_quo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pulse/busy accounting and scoreboard compare on done.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (divCtrl) divctrl_cnt++;
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_hi", hi, e[63:32]);
        chk("sb_lo", lo, e[31:0]);
      end
    end
  end

  // kind: 0 plain, 1 second start at inj, 2 hi_wr at inj, 4 start during DONE, 5 hi_wr with start
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int kind, input int inj);
    int  b_busy, b_dc, b_done, cyc;
    bit  seen;
    b_busy = busy_cnt; b_dc = divctrl_cnt; b_done = done_cnt;
    srcA = a; srcB = b; start = 1'b1;
    if (kind == 5) begin wr_data = 32'hAA; hi_wr = 1'b1; end
    sb_q.push_back({a % b, a / b});
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    cyc = 1;
    chk("load_divctrl", {31'd0, divCtrl}, 32'd1);
    chk("load_srcA", div_srcA, a);
    if (kind == 5) chk("coincident_hi_wr", hi, 32'hAA);
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      if (kind == 1 && cyc == inj) begin srcA = 32'd9; srcB = 32'd3; start = 1'b1; end
      if (kind == 2 && cyc == inj) begin wr_data = 32'h1; hi_wr = 1'b1; end
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("done_cycle", 32'(cyc), 32'd35);
    if (kind == 4) begin srcA = 32'd3; srcB = 32'd1; start = 1'b1; end
    @(negedge clk);
    start = 1'b0;
    if (kind == 4) begin
      chk("done_start_busy", {31'd0, busy}, 32'd0);
      chk("done_start_divctrl", {31'd0, divCtrl}, 32'd0);
    end
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    #1;
    chk("busy_cycles", 32'(busy_cnt - b_busy), 32'd34);
    chk("divctrl_cycles", 32'(divctrl_cnt - b_dc), 32'd1);
    chk("done_pulses", 32'(done_cnt - b_done), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    if (kind == 1) chk("ignored_start_srcA", div_srcA, a);
  endtask

  initial begin
    int b_dc;
    reset = 1'b0; start = 1'b0; srcA = '0; srcB = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_divctrl", {31'd0, divCtrl}, 32'd0);
    chk("rst_exc", {31'd0, div_zero_exc}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_srcA", div_srcA, 32'd0);
    chk("rst_srcB", div_srcB, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic divide 100/7.
    run_div(32'd100, 32'd7, 0, 0);

    // Divide by zero: exception pulse, no init, HI/LO untouched.
    b_dc = divctrl_cnt;
    srcA = 32'd5; srcB = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("exc_pulse", {31'd0, div_zero_exc}, 32'd1);
    chk("exc_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("exc_one_cycle", {31'd0, div_zero_exc}, 32'd0);
    chk("exc_no_divctrl", 32'(divctrl_cnt - b_dc), 32'd0);
    chk("exc_hi_kept", hi, 32'd2);
    chk("exc_lo_kept", lo, 32'd14);
    chk("exc_no_latch", div_srcB, 32'd7);

    // Second start while busy is ignored.
    run_div(32'd100, 32'd7, 1, 10);

    // Reset in the middle of a run.
    srcA = 32'd100; srcB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_divctrl", {31'd0, divCtrl}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_idle", {31'd0, busy}, 32'd0);
    run_div(32'd20, 32'd6, 0, 0);

    // MTHI/MTLO in IDLE.
    wr_data = 32'hDEADBEEF; hi_wr = 1'b1;
    @(negedge clk);
    hi_wr = 1'b0;
    wr_data = 32'h12345678; lo_wr = 1'b1;
    @(negedge clk);
    lo_wr = 1'b0;
    chk("mthi", hi, 32'hDEADBEEF);
    chk("mtlo", lo, 32'h12345678);

    // MTHI during RUN is ignored; capture wins.
    run_div(32'd100, 32'd7, 2, 5);

    // Boundary operands, plus a start during DONE that must be dropped.
    run_div(32'h7FFFFFFF, 32'd1, 4, 0);

    // Start coincident with MTHI in IDLE: write happens and start is accepted.
    run_div(32'd50, 32'd8, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_ctrl
